// File: rtl/ps2_host_tx_wishbone_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : ps2_pkg                                                      |
// | Brief  : Shared PS/2 host-transmitter definitions: FSM states,        |
// |          register offsets, STATUS bit indices, keyboard commands and  |
// |          the odd-parity helper.                                       |
// | Rev    : 1.0  initial release                                         |
// +----------------------------------------------------------------------+
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_INHIBIT   = 3'd1,
      ST_START     = 3'd2,
      ST_DATA      = 3'd3,
      ST_PARITY    = 3'd4,
      ST_STOP      = 3'd5,
      ST_WAIT_IDLE = 3'd6
   } ps2_state_e;

   // Byte offsets; only bits [3:2] are decoded.
   localparam logic [3:0] REG_TXDATA = 4'h0;
   localparam logic [3:0] REG_STATUS = 4'h4;
   localparam logic [3:0] REG_CTRL   = 4'h8;

   localparam int STS_BUSY = 0;
   localparam int STS_DONE = 1;
   localparam int STS_NACK = 2;
   localparam int STS_TMO  = 3;
   localparam int STS_OVR  = 4;

   localparam logic [7:0] CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] RSP_ACK      = 8'hFA;

   // PS/2 frames carry odd parity over the eight data bits.
   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_host_tx_wishbone_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : ps2_host_tx_wishbone_if                                      |
// | Brief  : Wishbone slave bundle (STB/WE/ADR/DAT in, DAT/ACK out).      |
// |          master modport drives the request, slave modport answers.    |
// | Rev    : 1.0  initial release                                         |
// +----------------------------------------------------------------------+
interface ps2_host_tx_wishbone_if #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32
);
   logic                     STB_I;
   logic                     WE_I;
   logic [ADDRESS_WIDTH-1:0] ADR_I;
   logic [DATA_WIDTH-1:0]    DAT_I;
   logic [DATA_WIDTH-1:0]    DAT_O;
   logic                     ACK_O;

   modport master (output STB_I, WE_I, ADR_I, DAT_I, input DAT_O, ACK_O);
   modport slave  (input STB_I, WE_I, ADR_I, DAT_I, output DAT_O, ACK_O);
endinterface
`default_nettype wire

// File: rtl/ps2_line_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : ps2_line_sync                                                |
// | Brief  : 2-flop synchroniser for one raw PS/2 line plus falling-edge  |
// |          detect (previous synced value 1, current 0).                 |
// | Ports  : clk, rst_n (async, active low), i_line (raw),               |
// |          o_sync (synchronised level), o_fe (one-cycle fall pulse)     |
// | Rev    : 1.0  initial release                                         |
// +----------------------------------------------------------------------+
module ps2_line_sync (
   input  wire logic clk,
   input  wire logic rst_n,
   input  wire logic i_line,
   output logic      o_sync,
   output logic      o_fe
);
   // [0],[1] synchroniser, [2] previous synced value. Reset to the idle
   // (high) level so no false edge appears when reset releases.
   logic [2:0] sr_q, sr_d;

   always_comb sr_d = {sr_q[1:0], i_line};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sr_q <= 3'b111;
      else        sr_q <= sr_d;
   end

   assign o_sync = sr_q[1];
   assign o_fe   = sr_q[2] & ~sr_q[1];
endmodule
`default_nettype wire

// File: rtl/ps2_host_tx_wishbone.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : ps2_host_tx_wishbone                                         |
// | Brief  : PS/2 host-to-device transmitter with Wishbone registers.     |
// | Ports  : CLK_I, RST_N_I (async active low), wb (Wishbone slave),     |
// |          k_clk/k_data raw lines in, k_clk_oe/k_data_oe pull-low       |
// |          enables, tx_busy (receiver gate), o_interrupt (level)        |
// | Rev    : 1.0  initial release                                         |
// +----------------------------------------------------------------------+
module ps2_host_tx_wishbone
   import ps2_pkg::*;
#(
   parameter int ADDRESS_WIDTH  = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  wire logic              CLK_I,
   input  wire logic              RST_N_I,
   ps2_host_tx_wishbone_if.slave  wb,
   input  wire logic              k_clk,
   input  wire logic              k_data,
   output logic                   k_clk_oe,
   output logic                   k_data_oe,
   output logic                   tx_busy,
   output logic                   o_interrupt
);
   localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   ps2_state_e            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [3:0]            bit_cnt_q, bit_cnt_d;
   logic [7:0]            byte_q, byte_d;
   logic                  clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
   logic [4:1]            sts_q, sts_d, sts_set, sts_clr;
   logic                  irq_en_q, irq_en_d, irq_q, irq_d, ack_q, ack_d;
   logic [DATA_WIDTH-1:0] dat_q, dat_d;

   logic clk_sync, clk_fe, data_sync, data_fe;
   logic acc, wr, rd, busy;
   logic [1:0] sel;
   logic unused_bits;

   ps2_line_sync u_clk_sync (.clk(CLK_I), .rst_n(RST_N_I), .i_line(k_clk),
                             .o_sync(clk_sync), .o_fe(clk_fe));
   ps2_line_sync u_data_sync (.clk(CLK_I), .rst_n(RST_N_I), .i_line(k_data),
                              .o_sync(data_sync), .o_fe(data_fe));

   // Register access happens on the edge that raises ACK; the ~ack_q term
   // keeps ACK from asserting on back-to-back cycles.
   assign acc  = wb.STB_I & ~ack_q;
   assign wr   = acc & wb.WE_I;
   assign rd   = acc & ~wb.WE_I;
   assign sel  = wb.ADR_I[3:2];
   assign busy = (state_q != ST_IDLE);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_cnt_d = bit_cnt_q;
      byte_d    = byte_q;
      clk_oe_d  = clk_oe_q;
      data_oe_d = data_oe_q;
      sts_set   = '0;

      // Watchdog runs in every line-driving phase after inhibit.
      if (state_q inside {ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_WAIT_IDLE})
         cnt_d = clk_fe ? '0 : cnt_q + CNT_W'(1);

      case (state_q)
         ST_IDLE: begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            if (wr && sel == REG_TXDATA[3:2]) begin
               byte_d   = wb.DAT_I[7:0];
               cnt_d    = '0;
               clk_oe_d = 1'b1;
               state_d  = ST_INHIBIT;
            end
         end
         ST_INHIBIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            // Start bit goes low during the final inhibit cycle.
            if (cnt_q == CNT_W'(INHIBIT_CYCLES - 2)) data_oe_d = 1'b1;
            if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
               clk_oe_d  = 1'b0;
               data_oe_d = 1'b1;
               cnt_d     = '0;
               state_d   = ST_START;
            end
         end
         ST_START: if (clk_fe) begin
            data_oe_d = ~byte_q[0];
            bit_cnt_d = 4'd1;
            state_d   = ST_DATA;
         end
         ST_DATA: if (clk_fe) begin
            if (bit_cnt_q < 4'd8) begin
               data_oe_d = ~byte_q[bit_cnt_q[2:0]];
               bit_cnt_d = bit_cnt_q + 4'd1;
            end else begin
               data_oe_d = ~odd_parity(byte_q);
               state_d   = ST_PARITY;
            end
         end
         ST_PARITY: if (clk_fe) begin
            data_oe_d = 1'b0;
            state_d   = ST_STOP;
         end
         ST_STOP: if (clk_fe) begin
            sts_set[STS_DONE] = 1'b1;
            sts_set[STS_NACK] = data_sync;
            state_d           = ST_WAIT_IDLE;
         end
         ST_WAIT_IDLE: if (clk_sync && data_sync) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (state_q inside {ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_WAIT_IDLE}
          && !clk_fe && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
         state_d   = ST_IDLE;
         clk_oe_d  = 1'b0;
         data_oe_d = 1'b0;
         // DONE is already set once WAIT_IDLE is reached, so a stuck line
         // there only abandons the wait instead of also flagging TMO.
         if (state_q != ST_WAIT_IDLE) sts_set[STS_TMO] = 1'b1;
      end

      sts_set[STS_OVR] = wr && sel == REG_TXDATA[3:2] && busy;
      sts_clr = (wr && sel == REG_STATUS[3:2]) ? wb.DAT_I[4:1] : 4'b0;
      // Hardware set wins over a simultaneous write-one-to-clear.
      sts_d    = (sts_q & ~sts_clr) | sts_set;
      irq_en_d = (wr && sel == REG_CTRL[3:2]) ? wb.DAT_I[0] : irq_en_q;
      irq_d    = irq_en_d & (|sts_d[STS_TMO:STS_DONE]);

      ack_d = acc;
      dat_d = '0;
      if (rd) begin
         if (sel == REG_STATUS[3:2])    dat_d[4:0] = {sts_q, busy};
         else if (sel == REG_CTRL[3:2]) dat_d[0]   = irq_en_q;
      end
   end

   always_ff @(posedge CLK_I or negedge RST_N_I) begin
      if (!RST_N_I) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         bit_cnt_q <= '0;
         byte_q    <= '0;
         clk_oe_q  <= 1'b0;
         data_oe_q <= 1'b0;
         sts_q     <= '0;
         irq_en_q  <= 1'b0;
         irq_q     <= 1'b0;
         ack_q     <= 1'b0;
         dat_q     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_cnt_q <= bit_cnt_d;
         byte_q    <= byte_d;
         clk_oe_q  <= clk_oe_d;
         data_oe_q <= data_oe_d;
         sts_q     <= sts_d;
         irq_en_q  <= irq_en_d;
         irq_q     <= irq_d;
         ack_q     <= ack_d;
         dat_q     <= dat_d;
      end
   end

   assign wb.DAT_O    = dat_q;
   assign wb.ACK_O    = ack_q;
   assign k_clk_oe    = clk_oe_q;
   assign k_data_oe   = data_oe_q;
   assign tx_busy     = busy;
   assign o_interrupt = irq_q;

   assign unused_bits = ^{wb.ADR_I[ADDRESS_WIDTH-1:4], wb.ADR_I[1:0],
                          wb.DAT_I[DATA_WIDTH-1:8]};
endmodule
`default_nettype wire
